// File: rtl/uart_rx_fifo_if.sv
// Receive stream from uart_rx_fifo: FIFO head with per-frame error flags.
// Latency n/a; master holds data/flags stable while valid && !ready.
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  parity_err;
    logic                  frame_err;

    modport master (output data, output valid, output parity_err, output frame_err, input ready);
    modport slave  (input data, input valid, input parity_err, input frame_err, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with run-time divisor/parity/stop mode feeding a FIFO; optional UART_RX_BREAK_DETECT_EN.
// valid rises 1 clk after the final stop sample; a full FIFO with no pop drops the frame and sets overrun.
module uart_rx_fifo #(
    parameter  int DATA_WIDTH    = 8,
    parameter  int FIFO_DEPTH    = 4,
    parameter  int DIV_WIDTH     = 16,
    localparam int LB_FIFO_DEPTH = $clog2(FIFO_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   sig,
    input  logic [DIV_WIDTH-1:0]   baud_div,
    input  logic [1:0]             parity_mode,
    input  logic                   two_stop,
    input  logic                   clr_overrun,
    uart_rx_fifo_if.master         rx,
    output logic                   overrun,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                   break_det,
`endif
    output logic [LB_FIFO_DEPTH:0] fifo_count
);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam int ENT_W = DATA_WIDTH + 2;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;

    logic [1:0]            sync_q;
    logic [2:0]            hist_q;
    state_t                state_q;
    logic [DIV_WIDTH-1:0]  cnt_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [BIT_W-1:0]      bits_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [1:0]            pmode_q;
    logic                  two_q;
    logic                  perr_q;
    logic                  ferr_q;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                  zero_q;
    logic                  brk_hold_q;
    logic                  break_q;
    logic                  brk_w;
`endif

    logic                  sample_w;
    logic                  fall_w;
    logic                  expire_w;
    logic                  par_en_w;
    logic                  final_w;
    logic                  push_w;
    logic                  frame_err_w;
    logic [DIV_WIDTH-1:0]  div_eff_w;

    assign sample_w  = (hist_q[0] & hist_q[1]) | (hist_q[1] & hist_q[2]) | (hist_q[0] & hist_q[2]);
    assign fall_w    = hist_q[0] & ~sync_q[1];
    assign expire_w  = (cnt_q == '0);
    assign par_en_w  = (pmode_q == 2'b01) || (pmode_q == 2'b10);
    assign div_eff_w = (baud_div < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : baud_div;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= 2'b11;
            hist_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[0], sig};
            hist_q <= {hist_q[1:0], sync_q[1]};
        end
    end

    always_comb begin
        final_w     = 1'b0;
        frame_err_w = ferr_q | ~sample_w;
        if (expire_w && ((state_q == S_STOP1 && !two_q) || state_q == S_STOP2))
            final_w = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
        brk_w  = final_w & zero_q & ~sample_w;
        push_w = final_w & ~brk_w;
`else
        push_w = final_w;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= DIV_WIDTH'(4);
            bits_q     <= '0;
            shreg_q    <= '0;
            pmode_q    <= 2'b00;
            two_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_q     <= 1'b0;
            brk_hold_q <= 1'b0;
            break_q    <= 1'b0;
`endif
        end else begin
`ifdef UART_RX_BREAK_DETECT_EN
            break_q <= brk_w;
`endif
            if (state_q != S_IDLE)
                cnt_q <= expire_w ? div_q - DIV_WIDTH'(1) : cnt_q - DIV_WIDTH'(1);
            case (state_q)
                S_IDLE: begin
`ifdef UART_RX_BREAK_DETECT_EN
                    // After a break the line must idle high for a whole bit before re-arming.
                    if (brk_hold_q) begin
                        if (!sample_w)     cnt_q      <= div_q - DIV_WIDTH'(1);
                        else if (expire_w) brk_hold_q <= 1'b0;
                        else               cnt_q      <= cnt_q - DIV_WIDTH'(1);
                    end else
`endif
                    if (fall_w) begin
                        div_q   <= div_eff_w;
                        pmode_q <= parity_mode;
                        two_q   <= two_stop;
                        cnt_q   <= div_eff_w >> 1;
                        state_q <= S_START;
                    end
                end
                S_START: if (expire_w) begin
                    if (sample_w) begin
                        state_q <= S_IDLE;
                    end else begin
                        bits_q  <= '0;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                        zero_q  <= 1'b1;
`endif
                        state_q <= S_DATA;
                    end
                end
                S_DATA: if (expire_w) begin
                    shreg_q <= {sample_w, shreg_q[DATA_WIDTH-1:1]};
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_q  <= zero_q & ~sample_w;
`endif
                    if (bits_q == BIT_W'(DATA_WIDTH - 1))
                        state_q <= par_en_w ? S_PARITY : S_STOP1;
                    else
                        bits_q <= bits_q + BIT_W'(1);
                end
                S_PARITY: if (expire_w) begin
                    perr_q  <= ((^shreg_q) ^ sample_w) != (pmode_q == 2'b10);
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_q  <= zero_q & ~sample_w;
`endif
                    state_q <= S_STOP1;
                end
                S_STOP1: if (expire_w) begin
                    ferr_q  <= ~sample_w;
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_q  <= zero_q & ~sample_w;
                    if (!two_q) brk_hold_q <= brk_w;
`endif
                    state_q <= two_q ? S_STOP2 : S_IDLE;
                end
                S_STOP2: if (expire_w) begin
`ifdef UART_RX_BREAK_DETECT_EN
                    brk_hold_q <= brk_w;
`endif
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    assign break_det = break_q;
`endif

    logic [ENT_W-1:0]         mem_q [FIFO_DEPTH];
    logic [LB_FIFO_DEPTH-1:0] wr_ptr_q;
    logic [LB_FIFO_DEPTH-1:0] rd_ptr_q;
    logic [LB_FIFO_DEPTH:0]   count_q;
    logic                     pop_w;
    logic                     full_w;
    logic                     wr_en_w;
    logic                     ovf_w;

    assign pop_w   = (count_q != '0) && rx.ready;
    assign full_w  = (count_q == (LB_FIFO_DEPTH+1)'(FIFO_DEPTH));
    assign wr_en_w = push_w && (!full_w || pop_w);
    assign ovf_w   = push_w && full_w && !pop_w;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overrun  <= 1'b0;
        end else begin
            if (wr_en_w) begin
                mem_q[wr_ptr_q] <= {frame_err_w, perr_q, shreg_q};
                wr_ptr_q        <= wr_ptr_q + LB_FIFO_DEPTH'(1);
            end
            if (pop_w) rd_ptr_q <= rd_ptr_q + LB_FIFO_DEPTH'(1);
            count_q <= count_q + (LB_FIFO_DEPTH+1)'(wr_en_w) - (LB_FIFO_DEPTH+1)'(pop_w);
            if (ovf_w)            overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end

    assign {rx.frame_err, rx.parity_err, rx.data} = mem_q[rd_ptr_q];
    assign rx.valid   = (count_q != '0);
    assign fifo_count = count_q;
endmodule
